rom_byte_reader: RTL and testbench
==================================

// Module: rom_byte_reader
// PURPOSE
//   Address sequencer and deserialiser that sits directly upstream of the 256x1 LUT-tree
//   ROM. It drives the ROM address and samples the ROM's 1-bit combinational output.
//   Each request reads byte_count bytes starting at base_addr; each byte is 8 consecutive
//   ROM bits, packed LSB-first and presented on a valid/ready output port.
// PARAMETERS
//   ADDR_W   8   ROM address width; the address space is 2**ADDR_W bits and wraps.
//   CNT_W    5   width of byte_count; a request reads at most 2**CNT_W-1 bytes.
// PORTS
//   CLK         in   1        single clock; all state updates on the rising edge.
//   RESETN      in   1        asynchronous, active-low reset.
//   start       in   1        request pulse; sampled only in IDLE.
//   base_addr   in   ADDR_W   first ROM bit address; sampled with start.
//   byte_count  in   CNT_W    number of bytes to read; sampled with start.
//   busy        out  1        high in every state except IDLE.
//   rom_addr    out  ADDR_W   registered address driving the ROM address input.
//   rom_data    in   1        combinational ROM output for the current rom_addr.
//   out_data    out  8        assembled byte; stable while out_valid is high.
//   out_valid   out  1        byte available.
//   out_ready   in   1        consumer accepts the byte when out_valid & out_ready.
//   done        out  1        one-cycle pulse when a request completes.
// BEHAVIOUR
// - Reset (RESETN low, asynchronous)
//   - state=IDLE; rom_addr=0; out_data=0; out_valid=0; busy=0; done=0.
//   - Internal bit and byte counters are cleared.
//   - A reset mid-request abandons the request; no done pulse is produced.
// - FSM: IDLE -> FETCH -> HOLD -> (FETCH | IDLE)
//   - IDLE, start=1, byte_count!=0: load rom_addr=base_addr, remaining=byte_count,
//     bitcnt=0; go to FETCH.
//   - IDLE, start=1, byte_count==0: stay in IDLE; pulse done on the next cycle.
//   - FETCH, each edge: shift[bitcnt]=rom_data; rom_addr=rom_addr+1 (mod 2**ADDR_W);
//     bitcnt++.
//   - FETCH, on the edge with bitcnt==7: out_data gets the complete byte; out_valid=1;
//     go to HOLD.
//   - HOLD: rom_addr, out_data and out_valid are frozen.
//   - HOLD, on the out_valid & out_ready edge: out_valid=0; remaining--.
//     If remaining was >1, go to FETCH with bitcnt=0; rom_addr already points at the
//     next bit.
//     Otherwise go to IDLE; done=1 for exactly the following cycle.
// - Latency
//   - First out_valid rises 9 edges after the edge that samples start
//     (1 load edge + 8 fetch edges).
//   - Each subsequent byte takes 8 more edges after the accepting edge.
// - Boundary conditions
//   - start while busy is ignored; base_addr and byte_count are not resampled.
//   - The address wraps 0xFF -> 0x00 silently, both inside a byte and across bytes.
//   - out_ready high outside HOLD has no effect.
//   - With out_ready held high, HOLD lasts exactly one cycle per byte.
//   - busy is low in the same cycle as the done pulse.
// STRUCTURE
// - Package rom_reader_pkg:
//   - state enum {IDLE, FETCH, HOLD};
//   - BITS_PER_BYTE=8;
//   - LAST_BIT=3'd7.
// - Sub-module rom_bit_deserializer: 8-bit LSB-first shift/capture register with load
//   strobe. Its ports are bit_in, bit_idx, capture and byte_out.
// - The top level holds the FSM, address counter and byte counter.
// - rom_addr is register-driven, so there is no combinational path from inputs to the ROM.
// TESTING  (ROM model: rom_data = rom_addr[0], i.e. LUT_INIT 16'hAAAA behaviour)
// 1. Single byte: base=0x00, count=1, out_ready=1.
//    -> out_valid 9 edges after start; out_data=0xAA; done pulse 1 cycle after accept.
// 2. Two bytes: base=0x01, count=2.
//    -> bytes 0x55 then 0x55; rom_addr steps 0x01..0x10; exactly one done pulse.
// 3. Wrap: base=0xFC, count=1.
//    -> rom_addr sequence FC,FD,FE,FF,00,01,02,03; out_data=0xAA.
// 4. Backpressure: count=2, out_ready=0 for 5 cycles during the first HOLD.
//    -> out_valid held; out_data=0xAA stable; rom_addr frozen; then resumes normally.
// 5. count=0 and start while busy: count=0 -> done next cycle, no out_valid.
//    A start pulse during FETCH is ignored and does not restart.
// 6. Reset mid-FETCH: assert RESETN=0 at bit 4.
//    -> all outputs 0 immediately; IDLE; no done; a new request after release works.

Source files
------------

// File: rtl/rom_reader_pkg.sv
// Purpose: shared types and constants for the ROM byte reader.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package rom_reader_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } state_e;

    localparam int         BITS_PER_BYTE = 8;
    localparam logic [2:0] LAST_BIT      = 3'd7;

endpackage

// File: rtl/rom_bit_deserializer.sv
// Purpose: 8-bit LSB-first shift/capture register fed one ROM bit per cycle.
// Latency: byte_out reflects the bit being written in the same cycle (combinational view).
// Backpressure: none; the writer gates capture.
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   bit_in     : incoming ROM bit
//   bit_idx    : byte position written by bit_in
//   capture    : write strobe; bit_in is stored at bit_idx on the rising edge
//   byte_out   : stored bits with the in-flight bit merged at bit_idx
module rom_bit_deserializer
    import rom_reader_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     bit_in,
    input  logic [2:0]               bit_idx,
    input  logic                     capture,
    output logic [BITS_PER_BYTE-1:0] byte_out
);

    logic [BITS_PER_BYTE-1:0] shift_q;
    logic [BITS_PER_BYTE-1:0] shift_d;

    // The merged view lets the caller grab the whole byte on the edge that
    // writes its last bit, without waiting an extra cycle.
    always_comb begin
        shift_d          = shift_q;
        shift_d[bit_idx] = bit_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q <= '0;
        end else if (capture) begin
            shift_q <= shift_d;
        end
    end

    assign byte_out = shift_d;

endmodule

// File: rtl/rom_byte_reader.sv
// Purpose: sequences ROM bit addresses and deserialises 8 bits per byte, LSB first.
// Latency: first byte valid on the 9th edge counting the start-sampling edge; +8 edges per later byte.
// Backpressure: out_valid/out_ready; in HOLD the address, data and valid are frozen until accepted.
// Ports:
//   CLK, RESETN           : clock and asynchronous active-low reset
//   start, base_addr,
//   byte_count            : request, sampled only in IDLE
//   busy                  : high outside IDLE
//   rom_addr / rom_data   : registered ROM address and its combinational 1-bit data
//   out_data, out_valid,
//   out_ready             : assembled byte stream
//   done                  : one-cycle pulse after a request completes
module rom_byte_reader
    import rom_reader_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int CNT_W  = 5
) (
    input  logic              CLK,
    input  logic              RESETN,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  byte_count,
    output logic              busy,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic              rom_data,
    output logic [7:0]        out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              done
);

    state_e            state_q,     state_d;
    logic [ADDR_W-1:0] addr_q,      addr_d;
    logic [CNT_W-1:0]  remaining_q, remaining_d;
    logic [2:0]        bitcnt_q,    bitcnt_d;
    logic [7:0]        out_data_q,  out_data_d;
    logic              out_valid_q, out_valid_d;
    logic              done_q,      done_d;

    logic              fetch_en;
    logic [7:0]        assembled;

    assign fetch_en = (state_q == FETCH);

    rom_bit_deserializer u_deser (
        .clk      (CLK),
        .rst_n    (RESETN),
        .bit_in   (rom_data),
        .bit_idx  (bitcnt_q),
        .capture  (fetch_en),
        .byte_out (assembled)
    );

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        bitcnt_d    = bitcnt_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        done_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (byte_count != '0) begin
                        addr_d      = base_addr;
                        remaining_d = byte_count;
                        bitcnt_d    = '0;
                        state_d     = FETCH;
                    end else begin
                        // Empty request completes immediately.
                        done_d = 1'b1;
                    end
                end
            end
            FETCH: begin
                // Address wraps naturally at 2**ADDR_W.
                addr_d   = addr_q + 1'b1;
                bitcnt_d = bitcnt_q + 1'b1;
                if (bitcnt_q == LAST_BIT) begin
                    out_data_d  = assembled;
                    out_valid_d = 1'b1;
                    state_d     = HOLD;
                end
            end
            HOLD: begin
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    remaining_d = remaining_q - 1'b1;
                    if (remaining_q > CNT_W'(1)) begin
                        // addr_q already points at the next byte's first bit.
                        bitcnt_d = '0;
                        state_d  = FETCH;
                    end else begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            remaining_q <= '0;
            bitcnt_q    <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            bitcnt_q    <= bitcnt_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            done_q      <= done_d;
        end
    end

    assign busy      = (state_q != IDLE);
    assign rom_addr  = addr_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign done      = done_q;

endmodule

// File: tb/tb_rom_byte_reader.sv
// Purpose: self-checking bench for rom_byte_reader against a ROM-array reference model.
// Latency: n/a.
// Backpressure: drives out_ready directed, stalled or random.
module tb_rom_byte_reader;

    logic       CLK;
    logic       RESETN;
    logic       start;
    logic [7:0] base_addr;
    logic [4:0] byte_count;
    logic       busy;
    logic [7:0] rom_addr;
    logic       rom_data;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       done;

    logic       rom_mem [256];

    int n_chk;
    int n_fail;

    rom_byte_reader #(.ADDR_W(8), .CNT_W(5)) dut (
        .CLK        (CLK),
        .RESETN     (RESETN),
        .start      (start),
        .base_addr  (base_addr),
        .byte_count (byte_count),
        .busy       (busy),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .done       (done)
    );

    assign rom_data = rom_mem[rom_addr];

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Byte k of a request: 8 consecutive ROM bits, address wrapping mod 256, LSB first.
    function automatic logic [7:0] exp_byte(input logic [7:0] base, input int k);
        logic [7:0] b;
        for (int j = 0; j < 8; j++) begin
            b[j] = rom_mem[(int'(base) + 8 * k + j) % 256];
        end
        return b;
    endfunction

    // mode 0: ready always high; mode 1: stall first HOLD 5 cycles; mode 2: random ready.
    // poke: pulse start with different arguments while the first byte is being fetched.
    task automatic run_req(input logic [7:0] base, input logic [4:0] cnt,
                           input int mode, input bit poke);
        int         edges;
        int         sob;
        int         nbytes;
        int         stall;
        int         fetched;
        logic       r;
        logic [7:0] exp_addr;
        @(negedge CLK);
        start      = 1'b1;
        base_addr  = base;
        byte_count = cnt;
        out_ready  = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
        @(negedge CLK);
        start      = 1'b0;
        base_addr  = 8'($urandom);
        byte_count = 5'($urandom);
        if (cnt == 5'd0) begin
            chk("zero_done", {31'd0, done}, 32'd1);
            chk("zero_busy", {31'd0, busy}, 32'd0);
            chk("zero_valid", {31'd0, out_valid}, 32'd0);
            @(negedge CLK);
            chk("zero_done_clr", {31'd0, done}, 32'd0);
            chk("zero_valid2", {31'd0, out_valid}, 32'd0);
            return;
        end
        edges  = 1;
        sob    = 1;
        nbytes = 0;
        stall  = 0;
        while (nbytes < int'(cnt) && edges < 2000) begin
            start   = 1'b0;
            fetched = edges - sob;
            if (fetched > 8) fetched = 8;
            exp_addr = 8'((int'(base) + 8 * nbytes + fetched) % 256);
            chk("rom_addr", {24'd0, rom_addr}, {24'd0, exp_addr});
            chk("busy", {31'd0, busy}, 32'd1);
            chk("done_low", {31'd0, done}, 32'd0);
            chk("out_valid", {31'd0, out_valid}, (fetched == 8) ? 32'd1 : 32'd0);
            if (out_valid) begin
                if (nbytes == 0 && stall == 0) chk("first_latency", edges, 32'd9);
                chk("out_data", {24'd0, out_data}, {24'd0, exp_byte(base, nbytes)});
                case (mode)
                    0:       r = 1'b1;
                    1:       r = (nbytes == 0 && stall < 5) ? 1'b0 : 1'b1;
                    default: r = ($urandom_range(0, 2) != 0);
                endcase
                out_ready = r;
                if (r) begin
                    nbytes++;
                    sob   = edges + 1;
                    stall = 0;
                end else begin
                    stall++;
                end
            end else begin
                out_ready = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
                if (poke && edges == 4) begin
                    start      = 1'b1;
                    base_addr  = ~base;
                    byte_count = 5'd7;
                end
            end
            @(negedge CLK);
            edges++;
        end
        chk("bytes_done", nbytes, 32'(cnt));
        chk("end_done", {31'd0, done}, 32'd1);
        chk("end_busy", {31'd0, busy}, 32'd0);
        chk("end_valid", {31'd0, out_valid}, 32'd0);
        out_ready = 1'b0;
        @(negedge CLK);
        chk("end_done_clr", {31'd0, done}, 32'd0);
        chk("end_idle", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        n_chk      = 0;
        n_fail     = 0;
        RESETN     = 1'b0;
        start      = 1'b0;
        base_addr  = 8'd0;
        byte_count = 5'd0;
        out_ready  = 1'b0;
        for (int i = 0; i < 256; i++) rom_mem[i] = i[0];

        #12;
        chk("rst_addr", {24'd0, rom_addr}, 32'd0);
        chk("rst_data", {24'd0, out_data}, 32'd0);
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        @(negedge CLK);
        RESETN = 1'b1;

        // Directed cases with rom_data = rom_addr[0].
        run_req(8'h00, 5'd1, 0, 1'b0);
        run_req(8'h01, 5'd2, 0, 1'b0);
        run_req(8'hFC, 5'd1, 0, 1'b0);
        run_req(8'h00, 5'd2, 1, 1'b0);
        run_req(8'h00, 5'd0, 0, 1'b0);
        run_req(8'h30, 5'd2, 0, 1'b1);

        // Reset in the middle of fetching bit 4.
        @(negedge CLK);
        start      = 1'b1;
        base_addr  = 8'h10;
        byte_count = 5'd3;
        @(negedge CLK);
        start = 1'b0;
        repeat (4) @(negedge CLK);
        chk("pre_rst_addr", {24'd0, rom_addr}, 32'h14);
        RESETN = 1'b0;
        #1;
        chk("mid_rst_addr", {24'd0, rom_addr}, 32'd0);
        chk("mid_rst_data", {24'd0, out_data}, 32'd0);
        chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_done", {31'd0, done}, 32'd0);
        @(negedge CLK);
        RESETN = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            chk("post_rst_done", {31'd0, done}, 32'd0);
            chk("post_rst_busy", {31'd0, busy}, 32'd0);
        end
        run_req(8'h20, 5'd2, 0, 1'b0);

        // Random ROM contents, random requests and random backpressure.
        for (int i = 0; i < 256; i++) rom_mem[i] = 1'($urandom);
        run_req(8'hF8, 5'd2, 2, 1'b0);
        for (int t = 0; t < 10; t++) begin
            run_req(8'($urandom), 5'($urandom_range(0, 4)), 2, 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
